// File: rtl/seg7_ascii_decoder.sv
// Decodes active-low 7-segment patterns back to uppercase ASCII and queues the
// results in a first-word-fall-through FIFO with sticky overflow reporting.
module seg7_ascii_decoder #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [6:0]    seg_n,
    input  logic          seg_valid,
    output logic          seg_ready,
    output logic [7:0]    ascii,
    output logic          ascii_unk,
    output logic          ascii_valid,
    input  logic          ascii_ready,
    output logic [CW-1:0] level,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] LVL_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    dec_char;
    logic          dec_unk;

    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [8:0]    head;

    // Shared glyphs resolve to the digit; 0x09 is always 'H'.
    always_comb begin
        dec_char = 8'h3F;
        dec_unk  = 1'b0;
        case (seg_n)
            7'h40: dec_char = 8'h30;
            7'h79: dec_char = 8'h31;
            7'h24: dec_char = 8'h32;
            7'h30: dec_char = 8'h33;
            7'h19: dec_char = 8'h34;
            7'h12: dec_char = 8'h35;
            7'h02: dec_char = 8'h36;
            7'h78: dec_char = 8'h37;
            7'h00: dec_char = 8'h38;
            7'h10: dec_char = 8'h39;
            7'h08: dec_char = 8'h41;
            7'h03: dec_char = 8'h42;
            7'h46: dec_char = 8'h43;
            7'h21: dec_char = 8'h44;
            7'h06: dec_char = 8'h45;
            7'h0E: dec_char = 8'h46;
            7'h09: dec_char = 8'h48;
            7'h4F: dec_char = 8'h49;
            7'h61: dec_char = 8'h4A;
            7'h47: dec_char = 8'h4C;
            7'h6A: dec_char = 8'h4D;
            7'h2A: dec_char = 8'h4E;
            7'h0C: dec_char = 8'h50;
            7'h18: dec_char = 8'h51;
            7'h2F: dec_char = 8'h52;
            7'h07: dec_char = 8'h54;
            7'h41: dec_char = 8'h55;
            7'h63: dec_char = 8'h56;
            7'h55: dec_char = 8'h57;
            7'h11: dec_char = 8'h59;
            7'h7D: dec_char = 8'h27;
            7'h7F: dec_char = 8'h20;
            default: begin
                dec_char = 8'h3F;
                dec_unk  = 1'b1;
            end
        endcase
    end

    always_comb begin
        full  = (level_q == FULL_LVL);
        empty = (level_q == '0);
        push  = seg_valid && !full;
        pop   = ascii_ready && !empty;
        head  = mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            mem_d[wr_ptr_q] = {dec_unk, dec_char};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // A new overflow in the same cycle as a clear must leave the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (seg_valid && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        seg_ready   = !full;
        ascii_valid = !empty;
        ascii       = empty ? 8'h00 : head[7:0];
        ascii_unk   = empty ? 1'b0  : head[8];
        level       = level_q;
        overflow    = ovf_q;
    end

endmodule

// File: tb/tb_seg7_ascii_decoder.sv
// Self-checking bench for seg7_ascii_decoder: a table-lookup queue model checked
// every cycle, plus directed scenarios pinned to hand-computed values.
module tb_seg7_ascii_decoder;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          rst_n;
    logic [6:0]    seg_n;
    logic          seg_valid;
    logic          seg_ready;
    logic [7:0]    ascii;
    logic          ascii_unk;
    logic          ascii_valid;
    logic          ascii_ready;
    logic [CW-1:0] level;
    logic          overflow;
    logic          clr_ovf;

    int checks = 0;
    int errors = 0;

    seg7_ascii_decoder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .ascii       (ascii),
        .ascii_unk   (ascii_unk),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .level       (level),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string      chars = "0123456789ABCDEFHIJLMNPQRTUVWY' ";
    logic [6:0] pats [32] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h09, 7'h4F, 7'h61, 7'h47,
        7'h6A, 7'h2A, 7'h0C, 7'h18, 7'h2F, 7'h07, 7'h41, 7'h63, 7'h55, 7'h11,
        7'h7D, 7'h7F
    };

    function automatic logic [8:0] refDecode(input logic [6:0] p);
        for (int i = 0; i < 32; i++) begin
            if (pats[i] == p) return {1'b0, 8'(chars.getc(i))};
        end
        return {1'b1, 8'h3F};
    endfunction

    logic [8:0] model_q [$];
    logic       model_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            bit do_push;
            bit do_pop;
            do_push = seg_valid && (model_q.size() < DEPTH);
            do_pop  = ascii_ready && (model_q.size() > 0);
            if (clr_ovf) model_ovf = 1'b0;
            if (seg_valid && model_q.size() >= DEPTH) model_ovf = 1'b1;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(refDecode(seg_n));
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic [8:0] exp_head;
            exp_head = (model_q.size() > 0) ? model_q[0] : 9'h000;
            checkOutput("model_valid", 16'(ascii_valid), 16'(model_q.size() > 0));
            checkOutput("model_ready", 16'(seg_ready), 16'(model_q.size() < DEPTH));
            checkOutput("model_level", 16'(level), 16'(model_q.size()));
            checkOutput("model_ovf", 16'(overflow), 16'(model_ovf));
            checkOutput("model_ascii", 16'(ascii), 16'(exp_head[7:0]));
            checkOutput("model_unk", 16'(ascii_unk), 16'(exp_head[8]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [6:0] p,
                                 input logic rdy, input logic clr);
        seg_valid   = v;
        seg_n       = p;
        ascii_ready = rdy;
        clr_ovf     = clr;
        step();
    endtask

    task automatic drainAll();
        for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(1'b0, 7'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0);
    endtask

    task automatic pushCheck(input logic [6:0] p, input logic [7:0] exp_c,
                             input logic exp_u);
        applyStimulus(1'b1, p, 1'b0, 1'b0);
        seg_valid = 1'b0;
        checkOutput("lat_valid", 16'(ascii_valid), 16'h1);
        checkOutput("lit_ascii", 16'(ascii), 16'(exp_c));
        checkOutput("lit_unk", 16'(ascii_unk), 16'(exp_u));
        applyStimulus(1'b0, 7'h00, 1'b1, 1'b0);
        ascii_ready = 1'b0;
    endtask

    logic [7:0] hell [4] = '{8'h48, 8'h45, 8'h4C, 8'h4C};

    initial begin
        rst_n = 1'b0;
        seg_valid = 1'b0;
        seg_n = 7'h00;
        ascii_ready = 1'b0;
        clr_ovf = 1'b0;
        #2;
        checkOutput("rst_valid", 16'(ascii_valid), 16'h0);
        checkOutput("rst_ready", 16'(seg_ready), 16'h1);
        checkOutput("rst_level", 16'(level), 16'h0);
        checkOutput("rst_ovf", 16'(overflow), 16'h0);
        checkOutput("rst_ascii", 16'(ascii), 16'h0);
        #10 rst_n = 1'b1;
        step();

        // Fill to full, overflow on the fifth, then drain "HELL".
        applyStimulus(1'b1, 7'h09, 1'b0, 1'b0);
        applyStimulus(1'b1, 7'h06, 1'b0, 1'b0);
        applyStimulus(1'b1, 7'h47, 1'b0, 1'b0);
        applyStimulus(1'b1, 7'h47, 1'b0, 1'b0);
        checkOutput("full_level", 16'(level), 16'h4);
        checkOutput("full_ready", 16'(seg_ready), 16'h0);
        applyStimulus(1'b1, 7'h40, 1'b0, 1'b0);
        checkOutput("ovf_set", 16'(overflow), 16'h1);
        seg_valid   = 1'b0;
        ascii_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("hell_char", 16'(ascii), 16'(hell[i]));
            checkOutput("hell_unk", 16'(ascii_unk), 16'h0);
            applyStimulus(1'b0, 7'h00, 1'b1, 1'b0);
        end
        checkOutput("drain_empty", 16'(ascii_valid), 16'h0);

        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1);
        clr_ovf = 1'b0;
        checkOutput("ovf_clear", 16'(overflow), 16'h0);

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, pats[i], 1'b0, 1'b0);
        applyStimulus(1'b1, 7'h08, 1'b0, 1'b1);
        checkOutput("ovf_set_wins", 16'(overflow), 16'h1);
        drainAll();

        pushCheck(7'h40, 8'h30, 1'b0);
        pushCheck(7'h10, 8'h39, 1'b0);
        pushCheck(7'h12, 8'h35, 1'b0);
        pushCheck(7'h24, 8'h32, 1'b0);
        pushCheck(7'h7F, 8'h20, 1'b0);
        pushCheck(7'h7D, 8'h27, 1'b0);
        pushCheck(7'h7E, 8'h3F, 1'b1);
        pushCheck(7'h08, 8'h41, 1'b0);

        // Steady stream at level 2: one push and one pop per cycle.
        applyStimulus(1'b1, pats[$urandom_range(0, 31)], 1'b0, 1'b0);
        applyStimulus(1'b1, pats[$urandom_range(0, 31)], 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 7'($urandom), 1'b1, 1'b0);
            checkOutput("stream_level", 16'(level), 16'h2);
        end
        drainAll();

        // Async reset between edges with three entries stored.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, pats[i + 10], 1'b0, 1'b0);
        seg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_level", 16'(level), 16'h0);
        checkOutput("arst_valid", 16'(ascii_valid), 16'h0);
        checkOutput("arst_ready", 16'(seg_ready), 16'h1);
        #2 rst_n = 1'b1;
        step();

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) ? pats[$urandom_range(0, 31)] : 7'($urandom),
                          (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 15) == 0);
        end
        drainAll();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_ascii_decoder.md
Name: seg7_ascii_decoder

Overview:
- Reverse path of the team's ASCII-to-7-segment encoder. Accepts active-low 7-segment patterns (bit0 = seg a … bit6 = seg g; 0 = lit) via a valid/ready strobe and decodes each one back to an uppercase ASCII code.
- Decoded characters are buffered in a small first-word-fall-through (FWFT) FIFO with valid/ready output, so a display-capture or scoreboard path can read text back from segment data.
- Patterns that are not in the table are flagged as unknown.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CW, 3, width of the `level` output; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  active-low segment pattern (bit0 = a … bit6 = g).
- seg_valid  input  1  `seg_n` holds a pattern to decode.
- seg_ready  output  1  block can accept a pattern; equals !full.
- ascii  output  8  decoded character at the FIFO head.
- ascii_unk  output  1  the head entry came from an unmapped pattern.
- ascii_valid  output  1  FIFO not empty.
- ascii_ready  input  1  consumer takes the head entry.
- level  output  CW  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: a pattern was offered while full.
- clr_ovf  input  1  synchronous clear of `overflow`.

Behaviour:
- Reset (async, rst_n=0):
  - Write pointer, read pointer and `level` go to 0.
  - overflow=0, ascii_valid=0, seg_ready=1.
  - `ascii` and `ascii_unk` read 0 while the FIFO is empty.
  - Reset mid-operation discards all stored entries immediately.
- Accept: a push happens when seg_valid && seg_ready at a rising edge.
  - The decode is combinational from `seg_n`. Each entry stores {unk, ascii[7:0]}, 9 bits.
- Latency: a pattern accepted at edge N into an empty FIFO is presented with ascii_valid=1 immediately after edge N.
- Pop: happens when ascii_valid && ascii_ready at an edge. The head advances and the next entry appears after the same edge.
- Simultaneous push and pop:
  - When not full: both occur and `level` is unchanged.
  - When full: seg_ready=0, so only the pop occurs.
  - When empty: only the push occurs. There is no bypass of the FIFO.
- Overflow: seg_valid && !seg_ready at an edge sets `overflow` and drops the pattern.
  - clr_ovf clears the flag. If clr_ovf and a new overflow event occur in the same cycle, set wins.
- Pointers: wrap modulo DEPTH. `level` is updated every cycle as +1 (push only), −1 (pop only) or unchanged.
- Decode table (seg_n hex → ASCII char):
  - Digits: 40→'0', 79→'1', 24→'2', 30→'3', 19→'4', 12→'5', 02→'6', 78→'7', 00→'8', 10→'9'.
  - Letters: 08→'A', 03→'B', 46→'C', 21→'D', 06→'E', 0E→'F', 09→'H', 4F→'I', 61→'J', 47→'L', 6A→'M', 2A→'N', 0C→'P', 18→'Q', 2F→'R', 07→'T', 41→'U', 63→'V', 55→'W', 11→'Y'.
  - Other: 7D→''' (apostrophe, 0x27), 7F→' ' (space, 0x20).
- Alias resolution is fixed:
  - Digits take priority where a pattern is shared: 40 is '0' not 'O'; 10 is '9' not 'G'; 12 is '5' not 'S'; 24 is '2' not 'Z'.
  - 09 decodes as 'H', never 'K' or 'X'.
  - All letters decode uppercase.
- Any pattern not listed decodes to '?' (0x3F) with unk=1. Listed patterns store unk=0.

Test Plan:
- Reset with no traffic → ascii_valid=0, seg_ready=1, level=0, overflow=0. Drop rst_n low while level=3 → level=0 and ascii_valid=0 at once, without waiting for a clock edge.
- Push 0x09, 0x06, 0x47, 0x47, 0x40 back-to-back with DEPTH=4 and ascii_ready=0:
  - First four are accepted; level=4 and seg_ready=0.
  - The fifth push sets overflow=1.
  - Draining then yields "HELL" (0x48, 0x45, 0x4C, 0x4C), all with unk=0.
- Alias check: push 0x40, 0x10, 0x12, 0x24, 0x7F, 0x7D → ascii = 0x30, 0x39, 0x35, 0x32, 0x20, 0x27.
- Unmapped pattern 0x7E → ascii=0x3F, ascii_unk=1. The entry that follows, 0x08, → 0x41 with ascii_unk=0.
- Hold seg_valid=1 and ascii_ready=1 continuously with level=2, cycling patterns:
  - One push and one pop per cycle; level stays at 2 and output order matches input order.
  - The first push into an empty FIFO is visible the cycle after acceptance.
- Assert clr_ovf while overflow=1 with no new overflow → flag clears. Assert clr_ovf while the FIFO is full and seg_valid=1 → overflow stays 1.
